// File: rtl/prbs8_checker.sv
// Serial checker for the x^8+x^4+x^3+x^2+1 PRBS stream: self-synchronises, declares lock,
// then counts bit errors against a free-running local copy of the generator.
module prbs8_checker #(
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             bit_valid_i,
    input  logic             bit_in_i,
    input  logic             clr_cnt_i,
    output logic             locked_o,
    output logic             bit_err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MissW  = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {StSeed, StSearch, StLocked} state_e;

    state_e             state_q;
    logic [7:0]         hist_q;
    logic [2:0]         fill_q;
    logic [MatchW-1:0]  match_q;
    logic [MissW-1:0]   miss_q;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               locked_q, bit_err_q;
    logic               pred, hit;

    always_comb begin
        pred = hist_q[4] ^ hist_q[3] ^ hist_q[2] ^ hist_q[0];
        hit  = (bit_in_i == pred);
    end

    // Saturating error count; a clear overrides a coincident increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bit_valid_i && (state_q == StLocked) && !hit && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        if (clr_cnt_i) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StSeed;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            locked_q  <= 1'b0;
            bit_err_q <= 1'b0;
        end else begin
            bit_err_q <= 1'b0;
            if (bit_valid_i) begin
                unique case (state_q)
                    StSeed: begin
                        hist_q <= {bit_in_i, hist_q[7:1]};
                        fill_q <= fill_q + 3'd1;
                        if (fill_q == 3'd7) begin
                            state_q <= StSearch;
                            match_q <= '0;
                        end
                    end
                    StSearch: begin
                        hist_q <= {bit_in_i, hist_q[7:1]};
                        // An all-zero history predicts zeros forever; never count it as sync.
                        if (hit && (hist_q != 8'h00)) begin
                            match_q <= match_q + 1'b1;
                            if (match_q == MatchW'(LOCK_CNT - 1)) begin
                                state_q  <= StLocked;
                                locked_q <= 1'b1;
                                miss_q   <= '0;
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end
                    StLocked: begin
                        // Free-run on the prediction so a single channel error counts once.
                        hist_q <= {pred, hist_q[7:1]};
                        if (!hit) begin
                            bit_err_q <= 1'b1;
                            miss_q    <= miss_q + 1'b1;
                            if (miss_q == MissW'(UNLOCK_CNT - 1)) begin
                                state_q  <= StSeed;
                                fill_q   <= '0;
                                locked_q <= 1'b0;
                            end
                        end else begin
                            miss_q <= '0;
                        end
                    end
                    default: state_q <= StSeed;
                endcase
            end
        end
    end

    assign locked_o  = locked_q;
    assign bit_err_o = bit_err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Randomised self-checking bench for prbs8_checker against a bit-history reference model.
module tb_prbs8_checker;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       bit_valid_i = 1'b0;
    logic       bit_in_i = 1'b0;
    logic       clr_cnt_i = 1'b0;
    logic       locked_o;
    logic       bit_err_o;
    logic [7:0] err_cnt_o;

    int checks = 0;
    int errors = 0;

    prbs8_checker #(
        .LOCK_CNT   (16),
        .UNLOCK_CNT (4),
        .CNT_W      (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bit_valid_i (bit_valid_i),
        .bit_in_i    (bit_in_i),
        .clr_cnt_i   (clr_cnt_i),
        .locked_o    (locked_o),
        .bit_err_o   (bit_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: 0 = seed, 1 = search, 2 = locked. hq holds the last 8 bits, oldest first.
    int   m_state, m_fill, m_match, m_miss, m_err;
    bit   m_locked, m_bit_err;
    bit   hq[$];
    logic [7:0] tx;
    int   pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit aged(input int age);
        return hq[hq.size() - age];
    endfunction

    // Next stream bit from the recurrence b[n] = b[n-4]^b[n-5]^b[n-6]^b[n-8].
    function automatic bit model_pred();
        return aged(4) ^ aged(5) ^ aged(6) ^ aged(8);
    endfunction

    function automatic bit hist_nonzero();
        int s = 0;
        foreach (hq[i]) s += int'(hq[i]);
        return s != 0;
    endfunction

    task automatic push_hist(input bit b);
        hq.push_back(b);
        void'(hq.pop_front());
    endtask

    task automatic model_step(input bit rst_n, input bit v, input bit b, input bit c);
        bit p;
        if (!rst_n) begin
            m_state = 0; m_fill = 0; m_match = 0; m_miss = 0; m_err = 0;
            m_locked = 0; m_bit_err = 0;
            hq.delete();
            repeat (8) hq.push_back(1'b0);
            return;
        end
        m_bit_err = 0;
        if (v) begin
            p = model_pred();
            if (m_state == 0) begin
                push_hist(b);
                m_fill++;
                if (m_fill == 8) begin m_state = 1; m_match = 0; end
            end else if (m_state == 1) begin
                if (b == p && hist_nonzero()) m_match++;
                else m_match = 0;
                push_hist(b);
                if (m_match == 16) begin m_state = 2; m_locked = 1; m_miss = 0; end
            end else begin
                push_hist(p);
                if (b != p) begin
                    m_bit_err = 1;
                    if (m_err < 255) m_err++;
                    m_miss++;
                    if (m_miss == 4) begin m_state = 0; m_fill = 0; m_locked = 0; end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (c) m_err = 0;
    endtask

    task automatic drive(input logic v, input logic b, input logic c);
        @(negedge clk_i);
        bit_valid_i = v;
        bit_in_i    = b;
        clr_cnt_i   = c;
        @(posedge clk_i);
        model_step(rst_ni, v, b, c);
        #1;
        check("locked", locked_o, m_locked);
        check("bit_err", bit_err_o, m_bit_err);
        check("err_cnt", err_cnt_o, m_err);
        pulses += int'(bit_err_o);
    endtask

    task automatic tx_bit(output logic b);
        b  = tx[0];
        tx = {tx[4] ^ tx[3] ^ tx[2] ^ tx[0], tx[7:1]};
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) drive(1'($urandom), 1'($urandom), 1'($urandom));
        rst_ni = 1'b1;
        tx     = 8'h01;
        pulses = 0;
    endtask

    initial begin
        logic b;
        int   n;

        // 1: reset with random inputs
        do_reset();
        check("rst_locked", locked_o, 0);
        check("rst_bit_err", bit_err_o, 0);
        check("rst_err_cnt", err_cnt_o, 0);

        // 2a: clean stream, lock exactly after beat 24
        for (int i = 1; i <= 600; i++) begin
            tx_bit(b);
            drive(1'b1, b, 1'b0);
            if (i == 23) check("lock_early", locked_o, 0);
            if (i == 24) check("lock_at_24", locked_o, 1);
        end
        check("clean_locked", locked_o, 1);
        check("clean_pulses", pulses, 0);
        check("clean_err", err_cnt_o, 0);

        // 2b: clean stream with random valid gaps
        do_reset();
        n = 0;
        while (n < 600) begin
            if ($urandom_range(0, 2) == 0) begin
                drive(1'b0, 1'($urandom), 1'b0);
            end else begin
                tx_bit(b);
                drive(1'b1, b, 1'b0);
                n++;
                if (n == 23) check("gap_lock_early", locked_o, 0);
                if (n == 24) check("gap_lock_at_24", locked_o, 1);
            end
        end
        check("gap_pulses", pulses, 0);
        check("gap_err", err_cnt_o, 0);

        // 3: single inverted bit at beat 100
        do_reset();
        for (int i = 1; i <= 150; i++) begin
            tx_bit(b);
            drive(1'b1, (i == 100) ? ~b : b, 1'b0);
        end
        check("single_pulses", pulses, 1);
        check("single_err", err_cnt_o, 1);
        check("single_locked", locked_o, 1);

        // 4: four consecutive errors drop lock, then relock after 24 clean beats
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            tx_bit(b);
            drive(1'b1, b, 1'b0);
        end
        for (int i = 1; i <= 4; i++) begin
            tx_bit(b);
            drive(1'b1, ~b, 1'b0);
            if (i == 3) check("burst_still_locked", locked_o, 1);
        end
        check("burst_unlocked", locked_o, 0);
        check("burst_err", err_cnt_o, 4);
        for (int i = 1; i <= 24; i++) begin
            tx_bit(b);
            drive(1'b1, b, 1'b0);
            if (i == 23) check("relock_early", locked_o, 0);
        end
        check("relocked", locked_o, 1);
        check("relock_err", err_cnt_o, 4);

        // 5: all-zero input never locks
        do_reset();
        repeat (100) drive(1'b1, 1'b0, 1'b0);
        check("zero_locked", locked_o, 0);
        check("zero_err", err_cnt_o, 0);

        // 6: every 2nd bit wrong keeps lock and saturates; clear beats a coincident error
        do_reset();
        repeat (30) begin
            tx_bit(b);
            drive(1'b1, b, 1'b0);
        end
        for (int i = 0; i < 600; i++) begin
            tx_bit(b);
            drive(1'b1, (i % 2 == 0) ? ~b : b, 1'b0);
        end
        check("sat_locked", locked_o, 1);
        check("sat_err", err_cnt_o, 255);
        tx_bit(b);
        drive(1'b1, ~b, 1'b1);
        check("clr_err", err_cnt_o, 0);
        check("clr_bit_err", bit_err_o, 1);

        // 7: random mix of gaps, flips, clears and resets against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, 1'($urandom), 1'($urandom_range(0, 31) == 0));
            end else begin
                tx_bit(b);
                drive(1'b1, ($urandom_range(0, 9) == 0) ? ~b : b,
                      1'($urandom_range(0, 63) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
